// File: rtl/shr_pkg.sv
// Shared constants and state encoding for the multi-cycle right shifter.
package shr_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shr_step.sv
// Combinational right shift by a small amount, filling vacated MSBs with fill.
module shr_step
  import shr_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               fill,
  output logic [DATA_W-1:0]  shifted
);

  logic [DATA_W-1:0] fill_mask;

  // Ones in the top amt bits when sign-filling, zero otherwise.
  assign fill_mask = fill ? ~({DATA_W{1'b1}} >> amt) : '0;
  assign shifted   = (data >> amt) | fill_mask;

endmodule

// File: rtl/shr32_seq.sv
// Multi-cycle 32-bit SRL/SRA: shifts STEP bits per cycle, start/done handshake, flush abort.
module shr32_seq
  import shr_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        arith,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   step_out;
  logic [SHAMT_W-1:0]  count_q, count_d;
  logic [SHAMT_W-1:0]  step_amt;
  logic                fill_q, fill_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                unused_a_hi;

  assign unused_a_hi = ^A[31:SHAMT_W];

  // A full STEP while enough shift remains, otherwise the leftover (possibly zero).
  assign step_amt = (count_q >= STEP_AMT) ? STEP_AMT : count_q;

  shr_step u_step (
    .data    (data_q),
    .amt     (step_amt),
    .fill    (fill_q),
    .shifted (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    fill_d  = fill_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          data_d  = B;
          count_d = A[SHAMT_W-1:0];
          fill_d  = arith & B[DATA_W-1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (count_q >= STEP_AMT) begin
          data_d  = step_out;
          count_d = count_q - STEP_AMT;
        end else begin
          data_d  = step_out;
          res_d   = step_out;
          count_d = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule
